// File: rtl/inv_result_serializer.sv
// inv_result_serializer
//
// Captures the four inverse elements produced by get_A_inv and streams them
// as a framed byte sequence on a valid/ready interface:
//   HDR_BYTE, A11..A22 (MSB byte first, 4*DATA_W/8 bytes), 8-bit sum checksum.
// A one-deep pending slot holds a result set that arrives mid-frame; a
// further set arriving while the slot is full is dropped and counted.
//
// Ports:
//   I_sys_clk       system clock, rising edge
//   I_sys_rst       asynchronous active-high reset
//   I_A11_inv..I_A22_inv  inverse elements, valid with I_A_inv_valid
//   I_A_inv_valid   one-cycle strobe for the four elements
//   O_tx_data       current stream byte
//   O_tx_valid      O_tx_data is valid
//   I_tx_ready      sink accepts the byte
//   O_busy          frame in progress or pending slot full
//   O_frame_done    pulse in the cycle after the checksum transfer
//   O_drop_cnt      saturating count of dropped result sets

module inv_result_serializer #(
    parameter int unsigned DATA_W   = 64,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic              I_sys_clk,
    input  logic              I_sys_rst,
    input  logic [DATA_W-1:0] I_A11_inv,
    input  logic [DATA_W-1:0] I_A12_inv,
    input  logic [DATA_W-1:0] I_A21_inv,
    input  logic [DATA_W-1:0] I_A22_inv,
    input  logic              I_A_inv_valid,
    output logic [7:0]        O_tx_data,
    output logic              O_tx_valid,
    input  logic              I_tx_ready,
    output logic              O_busy,
    output logic              O_frame_done,
    output logic [7:0]        O_drop_cnt
);

    localparam int unsigned BufW     = 4 * DATA_W;
    localparam int unsigned NumBytes = BufW / 8;
    localparam int unsigned IdxW     = $clog2(NumBytes);

    typedef enum logic [1:0] {StIdle, StHdr, StData, StCsum} state_e;

    state_e            state_q, state_d;
    logic [BufW-1:0]   active_q, active_d;
    logic [BufW-1:0]   pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [7:0]        acc_q, acc_d;
    logic [7:0]        drop_q, drop_d;
    logic              done_q, done_d;

    logic [BufW-1:0]   new_set;
    logic [7:0]        byte_sel;
    logic              xfer;
    logic              csum_xfer;

    // Flattened buffer keeps the wire order: A11 occupies the top bits.
    assign new_set = {I_A11_inv, I_A12_inv, I_A21_inv, I_A22_inv};

    always_comb begin
        byte_sel = 8'h00;
        for (int i = 0; i < NumBytes; i++) begin
            if (idx_q == IdxW'(i)) begin
                byte_sel = active_q[BufW-1-8*i -: 8];
            end
        end
    end

    // Outputs decode straight from state so reset clears them immediately.
    always_comb begin
        O_tx_valid = (state_q != StIdle);
        unique case (state_q)
            StIdle:  O_tx_data = 8'h00;
            StHdr:   O_tx_data = HDR_BYTE;
            StData:  O_tx_data = byte_sel;
            StCsum:  O_tx_data = acc_q;
            default: O_tx_data = 8'h00;
        endcase
    end

    assign xfer         = O_tx_valid && I_tx_ready;
    assign csum_xfer    = (state_q == StCsum) && xfer;
    assign O_busy       = (state_q != StIdle) || pend_vld_q;
    assign O_frame_done = done_q;
    assign O_drop_cnt   = drop_q;

    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        drop_d     = drop_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (I_A_inv_valid) begin
                    active_d = new_set;
                    state_d  = StHdr;
                end
            end
            StHdr: begin
                if (xfer) begin
                    acc_d   = 8'h00;
                    idx_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (xfer) begin
                    acc_d = acc_q + byte_sel;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IdxW'(NumBytes - 1)) begin
                        state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                if (xfer) begin
                    done_d = 1'b1;
                    if (pend_vld_q) begin
                        active_d   = pend_q;
                        pend_vld_d = 1'b0;
                        state_d    = StHdr;
                    end else if (I_A_inv_valid) begin
                        // New set passes through the empty pending slot.
                        active_d = new_set;
                        state_d  = StHdr;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Capture while a frame is running.
        if (I_A_inv_valid && (state_q != StIdle)) begin
            if (csum_xfer) begin
                // Slot is being vacated this cycle, so a refill never drops.
                if (pend_vld_q) begin
                    pend_d     = new_set;
                    pend_vld_d = 1'b1;
                end
            end else if (!pend_vld_q) begin
                pend_d     = new_set;
                pend_vld_d = 1'b1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
        if (I_sys_rst) begin
            state_q    <= StIdle;
            active_q   <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            idx_q      <= '0;
            acc_q      <= 8'h00;
            drop_q     <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            drop_q     <= drop_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_inv_result_serializer.sv
// Testbench for inv_result_serializer: scoreboard of expected stream bytes,
// table-driven frames plus hand-written multi-cycle corner cases.

module tb_inv_result_serializer;

    logic        clk;
    logic        rst;
    logic [63:0] a11, a12, a21, a22;
    logic        a_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        frame_done;
    logic [7:0]  drop_cnt;

    inv_result_serializer #(
        .DATA_W  (64),
        .HDR_BYTE(8'hA5)
    ) dut (
        .I_sys_clk    (clk),
        .I_sys_rst    (rst),
        .I_A11_inv    (a11),
        .I_A12_inv    (a12),
        .I_A21_inv    (a21),
        .I_A22_inv    (a22),
        .I_A_inv_valid(a_valid),
        .O_tx_data    (tx_data),
        .O_tx_valid   (tx_valid),
        .I_tx_ready   (tx_ready),
        .O_busy       (busy),
        .O_frame_done (frame_done),
        .O_drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a11;
        logic [63:0] a12;
        logic [63:0] a21;
        logic [63:0] a22;
        logic [7:0]  csum;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        bit         last;
    } sb_t;

    sb_t  sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;
    bit   expect_done = 1'b0;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [63:0] w, input int b);
        logic [63:0] t;
        t = w >> (56 - 8 * b);
        return t[7:0];
    endfunction

    function automatic logic [7:0] sum_of(input logic [63:0] w0, w1, w2, w3);
        logic [7:0] s;
        s = 8'h00;
        for (int b = 0; b < 8; b++) begin
            s = s + byte_of(w0, b) + byte_of(w1, b) + byte_of(w2, b) + byte_of(w3, b);
        end
        return s;
    endfunction

    task automatic push_frame(input logic [63:0] w0, w1, w2, w3, input logic [7:0] cs);
        logic [63:0] w[4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        sb_q.push_back('{data: 8'hA5, last: 1'b0});
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 8; b++) begin
                sb_q.push_back('{data: byte_of(w[k], b), last: 1'b0});
            end
        end
        sb_q.push_back('{data: cs, last: 1'b1});
    endtask

    // Leaves the caller at posedge+1 of the cycle after the capture edge.
    task automatic send_set(input logic [63:0] w0, w1, w2, w3);
        @(posedge clk); #1;
        a11 = w0; a12 = w1; a21 = w2; a22 = w3;
        a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !busy && !tx_valid) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d bytes outstanding expected 0", name, sb_q.size());
        end
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: compares every transferred byte and frame_done timing.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                expect_done = 1'b0;
            end else begin
                check("frame_done", frame_done, expect_done);
                if (frame_done && sb_q.size() > 0) begin
                    check("b2b_valid", tx_valid, 1'b1);
                    check("b2b_hdr", tx_data, 8'hA5);
                end
                expect_done = 1'b0;
                if (tx_valid && tx_ready) begin
                    n_tests++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_byte: got %0h expected none", tx_data);
                    end else begin
                        e = sb_q.pop_front();
                        if (tx_data !== e.data) begin
                            n_fail++;
                            $display("FAIL tx_byte: got %0h expected %0h", tx_data, e.data);
                        end
                        expect_done = e.last;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int run;
        int done_at;
        bit broken;
        bit found;

        vecs[0] = '{a11: 64'h1, a12: 64'h0, a21: 64'h0, a22: 64'h0, csum: 8'h01};
        vecs[1] = '{a11: '1, a12: '1, a21: '1, a22: '1, csum: 8'hE0};
        vecs[2] = '{a11: 64'h0, a12: 64'h0, a21: 64'h0, a22: 64'h0, csum: 8'h00};
        vecs[3] = '{a11: 64'h0101_0101_0101_0101, a12: 64'h0, a21: 64'h0, a22: 64'h0,
                    csum: 8'h08};
        vecs[4] = '{a11: 64'h0, a12: 64'hFF, a21: 64'h2, a22: 64'h0, csum: 8'h01};

        rst = 1'b1; a_valid = 1'b0; tx_ready = 1'b1;
        a11 = '0; a12 = '0; a21 = '0; a22 = '0;
        #1;
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_drop_cnt", drop_cnt, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // Latency and frame length for the first table entry.
        push_frame(vecs[0].a11, vecs[0].a12, vecs[0].a21, vecs[0].a22, vecs[0].csum);
        send_set(vecs[0].a11, vecs[0].a12, vecs[0].a21, vecs[0].a22);
        check("first_hdr_valid", tx_valid, 1'b1);
        check("first_hdr_data", tx_data, 8'hA5);
        run = 0; done_at = -1; broken = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_valid && !broken) run++;
            else broken = 1'b1;
            if (frame_done && done_at < 0) done_at = i;
        end
        check("valid_run_len", run, 34);
        check("frame_done_at", done_at, 34);
        wait_idle("v0");

        for (int v = 1; v < 5; v++) begin
            push_frame(vecs[v].a11, vecs[v].a12, vecs[v].a21, vecs[v].a22, vecs[v].csum);
            send_set(vecs[v].a11, vecs[v].a12, vecs[v].a21, vecs[v].a22);
            wait_idle("table");
        end
        check("drop_after_table", drop_cnt, 8'h00);

        // Backpressure on data byte 0x45.
        push_frame(64'h0123_4567_89AB_CDEF, 64'h0, 64'h0, 64'h0, 8'hC0);
        send_set(64'h0123_4567_89AB_CDEF, 64'h0, 64'h0, 64'h0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx_valid && tx_data == 8'h45) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("bp_found_45", found, 1'b1);
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold_data", tx_data, 8'h45);
            check("bp_hold_valid", tx_valid, 1'b1);
        end
        tx_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_resume", tx_data, 8'h67);
        wait_idle("bp");

        // Strobe on the checksum transfer cycle, pending empty.
        push_frame(64'h11, 64'h22, 64'h33, 64'h44, sum_of(64'h11, 64'h22, 64'h33, 64'h44));
        push_frame(64'hAA, 64'hBB, 64'hCC, 64'hDD, sum_of(64'hAA, 64'hBB, 64'hCC, 64'hDD));
        send_set(64'h11, 64'h22, 64'h33, 64'h44);
        repeat (33) @(posedge clk);
        #1;
        check("csum_cycle_data", tx_data, sum_of(64'h11, 64'h22, 64'h33, 64'h44));
        a11 = 64'hAA; a12 = 64'hBB; a21 = 64'hCC; a22 = 64'hDD;
        a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        check("coinc_hdr_valid", tx_valid, 1'b1);
        check("coinc_hdr_data", tx_data, 8'hA5);
        check("coinc_frame_done", frame_done, 1'b1);
        wait_idle("coinc");
        check("coinc_drop_cnt", drop_cnt, 8'h00);

        // Three strobes two cycles apart: third one is dropped.
        push_frame(64'h1111, 64'h2222, 64'h3333, 64'h4444,
                   sum_of(64'h1111, 64'h2222, 64'h3333, 64'h4444));
        push_frame(64'h5555, 64'h6666, 64'h7777, 64'h8888,
                   sum_of(64'h5555, 64'h6666, 64'h7777, 64'h8888));
        send_set(64'h1111, 64'h2222, 64'h3333, 64'h4444);
        send_set(64'h5555, 64'h6666, 64'h7777, 64'h8888);
        check("pending_busy", busy, 1'b1);
        send_set(64'h9999, 64'hAAAA, 64'hBBBB, 64'hCCCC);
        check("drop_cnt_one", drop_cnt, 8'h01);
        wait_idle("triple");
        check("drop_cnt_final", drop_cnt, 8'h01);

        // Reset in the middle of data byte 10.
        mon_en = 1'b0;
        send_set(64'h0, 64'h1122_3344_5566_7788, 64'h0, 64'h0);
        repeat (11) @(posedge clk);
        #1;
        check("mid_byte10", tx_data, 8'h33);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", tx_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_drop", drop_cnt, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        push_frame(64'hDEAD, 64'hBEEF, 64'h0, 64'h1, sum_of(64'hDEAD, 64'hBEEF, 64'h0, 64'h1));
        send_set(64'hDEAD, 64'hBEEF, 64'h0, 64'h1);
        check("post_rst_hdr", tx_data, 8'hA5);
        wait_idle("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
